// File: rtl/seg_scan_receiver.sv
// Receiver for a multiplexed two-digit 7-segment scan: waits for COM to settle in each phase,
// samples SEG once per visit and commits a hex digit after a run of matching samples.
module seg_scan_receiver #(
  parameter int unsigned SETTLE_CYC  = 8,
  parameter int unsigned MATCH_N     = 3,
  parameter int unsigned TIMEOUT_CYC = 200000,
  parameter bit          SEG_ACT_LOW = 1'b1,
  parameter bit          COM_ACT_LOW = 1'b1
) (
  input  logic       sysClk,
  input  logic       sysRst,
  input  logic [7:0] SEG,
  input  logic [1:0] COM,
  output logic [3:0] digit0,
  output logic [3:0] digit1,
  output logic [1:0] dp,
  output logic [1:0] valid,
  output logic       update,
  output logic       err,
  output logic [7:0] errCnt
);

  localparam logic [7:0]  SETTLE_LIM = 8'(SETTLE_CYC);
  localparam logic [3:0]  MATCH_LIM  = 4'(MATCH_N);
  localparam logic [23:0] TO_LIM     = 24'(TIMEOUT_CYC);
  localparam logic [23:0] TO_LAST    = 24'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

  // Returns {decodable, nibble} for an active-high a..g pattern.
  function automatic logic [4:0] decode_seg(input logic [6:0] pat);
    logic [4:0] res;
    case (pat)
      7'h3F:   res = {1'b1, 4'h0};
      7'h06:   res = {1'b1, 4'h1};
      7'h5B:   res = {1'b1, 4'h2};
      7'h4F:   res = {1'b1, 4'h3};
      7'h66:   res = {1'b1, 4'h4};
      7'h6D:   res = {1'b1, 4'h5};
      7'h7D:   res = {1'b1, 4'h6};
      7'h07:   res = {1'b1, 4'h7};
      7'h7F:   res = {1'b1, 4'h8};
      7'h6F:   res = {1'b1, 4'h9};
      7'h77:   res = {1'b1, 4'hA};
      7'h7C:   res = {1'b1, 4'hB};
      7'h39:   res = {1'b1, 4'hC};
      7'h5E:   res = {1'b1, 4'hD};
      7'h79:   res = {1'b1, 4'hE};
      7'h71:   res = {1'b1, 4'hF};
      default: res = {1'b0, 4'h0};
    endcase
    return res;
  endfunction

  logic [7:0]  seg_meta_r, seg_sync_r;
  logic [1:0]  com_meta_r, com_sync_r;
  logic [7:0]  seg_n_s;
  logic [1:0]  com_n_s;
  logic        phase_ok_s, phase_id_s;

  state_t      state_r, state_nx_s;
  logic        phase_r, phase_nx_s;
  logic [7:0]  settle_cnt_r, settle_nx_s;

  logic [4:0]  cand_r   [2];
  logic [3:0]  match_r  [2];
  logic [4:0]  held_r   [2];
  logic        valid_r  [2];
  logic [23:0] to_cnt_r [2];

  logic        sample_s, dec_ok_s, same_s, commit_s, changed_s;
  logic [4:0]  dec_s, cand_val_s;
  logic [3:0]  match_inc_s, match_new_s;
  logic [1:0]  expire_s;

  logic        err_r, upd_r;
  logic [7:0]  err_cnt_r;

  // Two-flop synchronizer on the scan lines.
  always_ff @(posedge sysClk) begin
    if (sysRst) begin
      seg_meta_r <= 8'h00;
      seg_sync_r <= 8'h00;
      com_meta_r <= 2'b00;
      com_sync_r <= 2'b00;
    end else begin
      seg_meta_r <= SEG;
      seg_sync_r <= seg_meta_r;
      com_meta_r <= COM;
      com_sync_r <= com_meta_r;
    end
  end

  assign seg_n_s    = SEG_ACT_LOW ? ~seg_sync_r : seg_sync_r;
  assign com_n_s    = COM_ACT_LOW ? ~com_sync_r : com_sync_r;
  assign phase_ok_s = (com_n_s == 2'b01) || (com_n_s == 2'b10);
  assign phase_id_s = com_n_s[1];

  // Scan FSM state register.
  always_ff @(posedge sysClk) begin
    if (sysRst) begin
      state_r      <= ST_IDLE;
      phase_r      <= 1'b0;
      settle_cnt_r <= 8'd0;
    end else begin
      state_r      <= state_nx_s;
      phase_r      <= phase_nx_s;
      settle_cnt_r <= settle_nx_s;
    end
  end

  // Next state: a phase change always restarts the settle window; none-phase drops to idle.
  always_comb begin
    state_nx_s  = state_r;
    phase_nx_s  = phase_r;
    settle_nx_s = settle_cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (phase_ok_s) begin
          state_nx_s  = ST_SETTLE;
          phase_nx_s  = phase_id_s;
          settle_nx_s = 8'd1;
        end else begin
          state_nx_s  = ST_IDLE;
        end
      end
      ST_SETTLE, ST_HOLD: begin
        if (!phase_ok_s) begin
          state_nx_s  = ST_IDLE;
        end else if (phase_id_s != phase_r) begin
          state_nx_s  = ST_SETTLE;
          phase_nx_s  = phase_id_s;
          settle_nx_s = 8'd1;
        end else if (state_r == ST_HOLD) begin
          state_nx_s  = ST_HOLD;
        end else if (settle_cnt_r >= SETTLE_LIM) begin
          state_nx_s  = ST_SAMPLE;
        end else begin
          settle_nx_s = settle_cnt_r + 8'd1;
        end
      end
      ST_SAMPLE: begin
        state_nx_s = ST_HOLD;
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  assign sample_s = (state_r == ST_SAMPLE);
  assign dec_s    = decode_seg(seg_n_s[6:0]);
  assign dec_ok_s = dec_s[4];

  // Match bookkeeping for the digit currently being sampled.
  always_comb begin
    cand_val_s = {dec_s[3:0], seg_n_s[7]};
    same_s     = (cand_val_s == cand_r[phase_r]);
    if (match_r[phase_r] >= MATCH_LIM) begin
      match_inc_s = MATCH_LIM;
    end else begin
      match_inc_s = match_r[phase_r] + 4'd1;
    end
    if (same_s) begin
      match_new_s = match_inc_s;
    end else begin
      match_new_s = 4'd1;
    end
    commit_s  = sample_s && dec_ok_s && (match_new_s == MATCH_LIM);
    changed_s = !valid_r[phase_r] || (held_r[phase_r] != cand_val_s);
    expire_s  = {(to_cnt_r[1] >= TO_LAST), (to_cnt_r[0] >= TO_LAST)};
  end

  // Per-digit candidate, commit and timeout; a sample of a digit overrides its timeout.
  always_ff @(posedge sysClk) begin
    if (sysRst) begin
      for (int p = 0; p < 2; p++) begin
        cand_r[p]   <= 5'd0;
        match_r[p]  <= 4'd0;
        held_r[p]   <= 5'd0;
        valid_r[p]  <= 1'b0;
        to_cnt_r[p] <= 24'd0;
      end
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (sample_s && (phase_r == p[0])) begin
          to_cnt_r[p] <= 24'd0;
          if (dec_ok_s) begin
            cand_r[p]  <= cand_val_s;
            match_r[p] <= match_new_s;
            if (commit_s) begin
              held_r[p]  <= cand_val_s;
              valid_r[p] <= 1'b1;
            end
          end else begin
            match_r[p] <= 4'd0;
          end
        end else if (expire_s[p]) begin
          to_cnt_r[p] <= TO_LIM;
          valid_r[p]  <= 1'b0;
          match_r[p]  <= 4'd0;
        end else begin
          to_cnt_r[p] <= to_cnt_r[p] + 24'd1;
        end
      end
    end
  end

  // Event pulses and saturating error count.
  always_ff @(posedge sysClk) begin
    if (sysRst) begin
      err_r     <= 1'b0;
      upd_r     <= 1'b0;
      err_cnt_r <= 8'd0;
    end else begin
      err_r <= sample_s && !dec_ok_s;
      upd_r <= commit_s && changed_s;
      if (sample_s && !dec_ok_s && (err_cnt_r != 8'hFF)) begin
        err_cnt_r <= err_cnt_r + 8'd1;
      end else begin
        err_cnt_r <= err_cnt_r;
      end
    end
  end

  assign digit0 = held_r[0][4:1];
  assign digit1 = held_r[1][4:1];
  assign dp     = {held_r[1][0], held_r[0][0]};
  assign valid  = {valid_r[1], valid_r[0]};
  assign update = upd_r;
  assign err    = err_r;
  assign errCnt = err_cnt_r;

endmodule

// File: tb/tb_seg_scan_receiver.sv
// Scoreboard bench for seg_scan_receiver: scan visits are generated, a behavioural model predicts
// each err/update pulse, and a monitor compares every pulse the DUT presents.
module tb_seg_scan_receiver;

  localparam int SETTLE   = 8;
  localparam int MATCHN   = 3;
  localparam int TO_CYC   = 4000;
  localparam int LONG_MIN = SETTLE + 4;
  localparam logic [6:0] SEG_TAB [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                          7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  logic       sysClk, sysRst;
  logic [7:0] SEG;
  logic [1:0] COM;
  logic [3:0] digit0, digit1;
  logic [1:0] dp, valid;
  logic       update, err;
  logic [7:0] errCnt;

  seg_scan_receiver #(
    .SETTLE_CYC(SETTLE), .MATCH_N(MATCHN), .TIMEOUT_CYC(TO_CYC),
    .SEG_ACT_LOW(1'b1), .COM_ACT_LOW(1'b1)
  ) dut (
    .sysClk(sysClk), .sysRst(sysRst), .SEG(SEG), .COM(COM),
    .digit0(digit0), .digit1(digit1), .dp(dp), .valid(valid),
    .update(update), .err(err), .errCnt(errCnt)
  );

  initial begin
    sysClk = 1'b0;
    forever #5 sysClk = ~sysClk;
  end

  typedef struct {
    bit         is_err;
    logic [7:0] cnt;
    logic [3:0] d0, d1;
    logic [1:0] dpv, vld;
  } ev_t;

  ev_t sb_q[$];
  int  checks = 0;
  int  failures = 0;
  int  upd_count = 0;
  int  err_count = 0;

  // reference model state: {nibble, dp} per digit
  logic [4:0] m_cand [2];
  int         m_match [2];
  logic [4:0] m_held [2];
  bit         m_valid [2];
  int         m_errcnt;
  logic [7:0] cur_val [2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int p = 0; p < 2; p++) begin
      m_cand[p] = 5'd0; m_match[p] = 0; m_held[p] = 5'd0; m_valid[p] = 1'b0;
    end
    m_errcnt = 0;
  endfunction

  function automatic void model_sample(input int p, input logic [7:0] s);
    int idx = -1;
    ev_t e;
    logic [4:0] v;
    for (int i = 0; i < 16; i++) if (SEG_TAB[i] == s[6:0]) idx = i;
    e.is_err = 1'b0; e.cnt = 8'd0; e.d0 = 4'd0; e.d1 = 4'd0; e.dpv = 2'd0; e.vld = 2'd0;
    if (idx < 0) begin
      m_errcnt = (m_errcnt < 255) ? m_errcnt + 1 : 255;
      m_match[p] = 0;
      e.is_err = 1'b1;
      e.cnt = 8'(m_errcnt);
      sb_q.push_back(e);
    end else begin
      v = {4'(idx), s[7]};
      if (v == m_cand[p]) m_match[p] = (m_match[p] < MATCHN) ? m_match[p] + 1 : MATCHN;
      else begin m_cand[p] = v; m_match[p] = 1; end
      if (m_match[p] == MATCHN) begin
        bit changed = !m_valid[p] || (m_held[p] != v);
        m_held[p] = v;
        m_valid[p] = 1'b1;
        if (changed) begin
          e.d0 = m_held[0][4:1]; e.d1 = m_held[1][4:1];
          e.dpv = {m_held[1][0], m_held[0][0]};
          e.vld = {m_valid[1], m_valid[0]};
          sb_q.push_back(e);
        end
      end
    end
  endfunction

  // ph: 0/1 = digit phase, 2 = no digit selected, 3 = both selected; seg_ah is active-high
  task automatic visit(input int ph, input logic [7:0] seg_ah, input int dur);
    case (ph)
      0:       COM = 2'b10;
      1:       COM = 2'b01;
      2:       COM = 2'b11;
      default: COM = 2'b00;
    endcase
    SEG = ~seg_ah;
    if (ph < 2 && dur >= LONG_MIN) model_sample(ph, seg_ah);
    repeat (dur) @(negedge sysClk);
  endtask

  task automatic do_reset();
    sysRst = 1'b1; COM = 2'b11; SEG = 8'hFF;
    repeat (3) @(negedge sysClk);
    sysRst = 1'b0;
    model_reset();
    sb_q.delete();
  endtask

  task automatic drain(input string name);
    visit(2, 8'h00, 30);
    check(name, sb_q.size(), 0);
    sb_q.delete();
  endtask

  // Monitor: every err/update pulse must match the oldest outstanding prediction.
  always @(negedge sysClk) begin
    if (!sysRst && (err || update)) begin
      if (update) upd_count++;
      if (err) err_count++;
      if (sb_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_pulse err=%0b update=%0b expected=none", err, update);
      end else begin
        ev_t e;
        e = sb_q.pop_front();
        check("pulse_err", err, e.is_err);
        check("pulse_update", update, !e.is_err);
        if (e.is_err) check("ev_errCnt", errCnt, e.cnt);
        else begin
          check("ev_digit0", digit0, e.d0);
          check("ev_digit1", digit1, e.d1);
          check("ev_dp", dp, e.dpv);
          check("ev_valid", valid, e.vld);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    int u0, e0, n;
    bit seen;
    sysRst = 1'b1; COM = 2'b11; SEG = 8'hFF;
    for (int p = 0; p < 2; p++) cur_val[p] = 8'h3F;

    // reset state
    do_reset();
    check("rst_digit0", digit0, 0); check("rst_digit1", digit1, 0);
    check("rst_dp", dp, 0);         check("rst_valid", valid, 0);
    check("rst_update", update, 0); check("rst_err", err, 0);
    check("rst_errCnt", errCnt, 0);

    // digit0 shows 3 after three matching visits
    u0 = upd_count;
    for (int i = 0; i < 3; i++) begin visit(0, 8'h4F, 40); visit(1, 8'h00, 6); end
    visit(2, 8'h00, 20);
    check("a_digit0", digit0, 4'h3); check("a_dp", dp, 2'b00);
    check("a_valid", valid, 2'b01); check("a_updates", upd_count - u0, 1);
    drain("a_drain");

    // both digits
    do_reset();
    u0 = upd_count;
    for (int i = 0; i < 3; i++) begin visit(0, 8'hF7, 30); visit(1, 8'h06, 30); end
    visit(2, 8'h00, 20);
    check("b_digit0", digit0, 4'hA); check("b_digit1", digit1, 4'h1);
    check("b_dp", dp, 2'b01); check("b_valid", valid, 2'b11);
    check("b_updates", upd_count - u0, 2);
    drain("b_drain");

    // alternating values never commit
    do_reset();
    u0 = upd_count; e0 = err_count;
    for (int i = 0; i < 8; i++) begin visit(0, (i % 2 == 0) ? 8'h06 : 8'h5B, 30); visit(1, 8'h00, 6); end
    visit(2, 8'h00, 20);
    check("c_valid", valid, 2'b00); check("c_updates", upd_count - u0, 0);
    check("c_errs", err_count - e0, 0);
    drain("c_drain");

    // blank samples raise err and saturate errCnt
    do_reset();
    e0 = err_count;
    for (int i = 0; i < 5; i++) begin visit(1, 8'h00, 20); visit(0, 8'h00, 6); end
    visit(2, 8'h00, 20);
    check("d_errCnt5", errCnt, 8'd5); check("d_errs5", err_count - e0, 5);
    check("d_valid", valid, 2'b00);
    for (int i = 0; i < 300; i++) begin visit(1, 8'h00, LONG_MIN); visit(0, 8'h00, 5); end
    visit(2, 8'h00, 20);
    check("d_errCnt_sat", errCnt, 8'd255); check("d_valid_sat", valid, 2'b00);
    drain("d_drain");

    // overlap between phases delays but does not corrupt
    do_reset();
    for (int i = 0; i < 3; i++) begin
      visit(0, 8'h66, 20); visit(3, 8'h00, 4); visit(1, 8'h5B, 20); visit(3, 8'h00, 4);
    end
    visit(2, 8'h00, 20);
    check("e_digit0", digit0, 4'h4); check("e_digit1", digit1, 4'h2);
    check("e_valid", valid, 2'b11);
    drain("e_drain");

    // randomized visits against the model
    do_reset();
    begin
      int ph = 0;
      for (int i = 0; i < 150; i++) begin
        int dur;
        if ($urandom_range(0, 3) == 0) begin
          if ($urandom_range(0, 9) < 7) cur_val[ph] = {1'($urandom_range(0, 1)), SEG_TAB[$urandom_range(0, 15)]};
          else cur_val[ph] = 8'($urandom);
        end
        dur = ($urandom_range(0, 9) < 7) ? $urandom_range(LONG_MIN, 30) : $urandom_range(2, SETTLE);
        visit(ph, cur_val[ph], dur);
        if ($urandom_range(0, 9) < 3) visit($urandom_range(2, 3), 8'h00, $urandom_range(1, 5));
        ph = 1 - ph;
      end
    end
    drain("r_drain");
    check("r_digit0", digit0, m_held[0][4:1]); check("r_digit1", digit1, m_held[1][4:1]);
    check("r_dp", dp, {m_held[1][0], m_held[0][0]});
    check("r_valid", valid, {m_valid[1], m_valid[0]});

    // digit1 times out while COM is stuck on digit0
    do_reset();
    fork
      begin
        for (int i = 0; i < 3; i++) begin
          visit(1, 8'h6F, 20);
          if (i < 2) visit(0, 8'h00, 6);
        end
        visit(0, 8'h3F, TO_CYC + 40);
      end
      begin
        seen = 1'b0;
        for (int k = 0; k < 3000 && !seen; k++) begin
          @(negedge sysClk);
          if (update && valid[1]) seen = 1'b1;
        end
        check("t_commit_seen", seen, 1'b1);
        n = 0;
        while (valid[1] && n < TO_CYC + 100) begin @(negedge sysClk); n++; end
        check("t_latency", n, TO_CYC);
        check("t_digit1_kept", digit1, 4'h9);
        check("t_valid", valid, 2'b00);
      end
    join
    drain("t_drain");

    // reset mid-settle clears outputs and discards partial matches
    do_reset();
    visit(0, 8'h00, 20);
    for (int i = 0; i < 2; i++) begin visit(1, 8'h7F, 20); visit(0, 8'h07, 20); end
    visit(1, 8'h7F, 20);
    check("m_pre_digit1", digit1, 4'h8); check("m_pre_valid", valid, 2'b10);
    check("m_pre_errCnt", errCnt, 8'd1); check("m_pre_pending", sb_q.size(), 0);
    COM = 2'b10; SEG = ~8'h07;
    repeat (5) @(negedge sysClk);
    sysRst = 1'b1;
    @(negedge sysClk);
    check("m_digit0", digit0, 0); check("m_digit1", digit1, 0);
    check("m_dp", dp, 0);         check("m_valid", valid, 0);
    check("m_update", update, 0); check("m_err", err, 0);
    check("m_errCnt", errCnt, 0);
    sysRst = 1'b0;
    model_reset();
    sb_q.delete();
    for (int i = 0; i < 2; i++) begin visit(1, 8'h00, 6); visit(0, 8'h07, 20); end
    visit(2, 8'h00, 20);
    check("m_no_commit", valid, 2'b00);
    visit(1, 8'h00, 6); visit(0, 8'h07, 20);
    visit(2, 8'h00, 20);
    check("m_digit0_after", digit0, 4'h7); check("m_valid_after", valid, 2'b01);
    drain("m_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
